// File: rtl/instr_decode_pkg.sv
// rv_decode_pkg: opcodes, funct3 codes, FSM states and decoded-bundle type shared by the decoder
package rv_decode_pkg;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_BR_RSV0 = 3'b010;
    localparam logic [2:0] F3_BR_RSV1 = 3'b011;
    localparam logic [2:0] FCS_JAL    = 3'b010;
    localparam logic [2:0] FCS_JALR   = 3'b011;
    typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;
    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_Z} fmt_t;
    typedef struct packed {
        logic        lup;
        logic        ub;
        logic        cb;
        logic        mem;
        logic        alu_imm;
        logic        alu_reg;
        logic        iop;
        logic        fc;
        logic [2:0]  fcs;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } bundle_t;
endpackage

// File: rtl/instr_decode_if.sv
// instr_decode_if: fetch-side handshake, flush and execute-side decoded bundle
interface instr_decode_if;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc_in, imm, pc_out;
    logic        LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC, illegal;
    logic [2:0]  finite_control_sig;
    logic [4:0]  rs1, rs2, rd;
    logic [15:0] illegal_count;
    modport master (
        output in_valid, instr, pc_in, flush, out_ready,
        input  in_ready, out_valid, LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC,
               finite_control_sig, rs1, rs2, rd, imm, pc_out, illegal, illegal_count
    );
    modport slave (
        input  in_valid, instr, pc_in, flush, out_ready,
        output in_ready, out_valid, LUP, UB, CB, MEM, ALU_IMM, ALU_REG, IOP, FC,
               finite_control_sig, rs1, rs2, rd, imm, pc_out, illegal, illegal_count
    );
endinterface

// File: rtl/instr_decode_imm_gen.sv
// imm_gen: sign-extended RV32I immediate for the selected instruction format
module imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr,
    input  fmt_t        fmt,
    output logic [31:0] imm
);
    assign imm = fmt == FMT_I ? {{20{instr[31]}}, instr[31:20]} :
                 fmt == FMT_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                 fmt == FMT_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                 fmt == FMT_U ? {instr[31:12], 12'b0} :
                 fmt == FMT_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                 32'b0;
endmodule

// File: rtl/instr_decode.sv
// instr_decode: single-register-stage RV32I decoder with valid/ready handshake, flush and illegal counter
module instr_decode
    import rv_decode_pkg::*;
(
    input logic clk,
    input logic rst,
    instr_decode_if.slave bus
);
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] pc_q;
    logic [15:0] cnt;
    logic        accept;
    fmt_t        fmt;
    bundle_t     d, q;
    state_t      state;

    assign op  = bus.instr[6:2];
    assign f3  = bus.instr[14:12];
    assign fmt = (op == OP_LUI || op == OP_AUIPC) ? FMT_U :
                 op == OP_JAL    ? FMT_J :
                 op == OP_BRANCH ? FMT_B :
                 op == OP_STORE  ? FMT_S :
                 op == OP_REG    ? FMT_Z : FMT_I;

    imm_gen u_imm (.instr(bus.instr), .fmt(fmt), .imm(imm));

    always_comb begin
        d = '0;
        d.illegal = bus.instr[1:0] != 2'b11;
        case (op)
            OP_LUI:    begin d.lup = 1'b1; d.iop = 1'b1; end
            OP_AUIPC:  d.lup = 1'b1;
            OP_JAL:    begin d.ub = 1'b1; d.fcs = FCS_JAL; end
            OP_JALR:   begin d.ub = 1'b1; d.fcs = FCS_JALR; end
            OP_BRANCH: begin
                d.cb = 1'b1;
                d.fcs = f3;
                d.illegal = d.illegal | f3 == F3_BR_RSV0 | f3 == F3_BR_RSV1;
            end
            OP_LOAD:   begin d.mem = 1'b1; d.fcs = f3; end
            OP_STORE:  begin d.mem = 1'b1; d.fc = 1'b1; d.fcs = f3; end
            OP_IMM:    begin d.alu_imm = 1'b1; d.fcs = f3; d.iop = f3 == F3_SR && bus.instr[30]; end
            OP_REG:    begin
                d.alu_reg = 1'b1;
                d.fcs = f3;
                d.iop = bus.instr[30];
                // only SUB and SRA may carry funct7[5]; every other funct7 bit is reserved
                d.illegal = d.illegal | bus.instr[31] | (|bus.instr[29:25]) |
                            (bus.instr[30] && f3 != F3_ADD && f3 != F3_SR);
            end
            default:   d.illegal = 1'b1;
        endcase
        if (d.illegal) {d.lup, d.ub, d.cb, d.mem, d.alu_imm, d.alu_reg, d.iop, d.fc, d.fcs} = '0;
        d.rs1 = bus.instr[19:15];
        d.rs2 = bus.instr[24:20];
        d.rd  = bus.instr[11:7];
        d.imm = imm;
    end

    assign bus.out_valid = state != EMPTY;
    assign bus.in_ready  = !bus.out_valid || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            q     <= '0;
            pc_q  <= '0;
            cnt   <= '0;
        end else if (bus.flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state <= FULL;
            q     <= d;
            pc_q  <= bus.pc_in;
            cnt   <= (d.illegal && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
        end else if (state != EMPTY) begin
            state <= bus.out_ready ? EMPTY : STALL;
        end
    end

    assign {bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG} =
           {q.lup, q.ub, q.cb, q.mem, q.alu_imm, q.alu_reg};
    assign bus.IOP                = q.iop;
    assign bus.FC                 = q.fc;
    assign bus.finite_control_sig = q.fcs;
    assign bus.rs1                = q.rs1;
    assign bus.rs2                = q.rs2;
    assign bus.rd                 = q.rd;
    assign bus.imm                = q.imm;
    assign bus.illegal            = q.illegal;
    assign bus.pc_out             = pc_q;
    assign bus.illegal_count      = cnt;
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: vector table, handshake corner sequences and random traffic against a reference model
module tb_instr_decode;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_decode_if bus();
    instr_decode dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [5:0]  cls;
        logic        iop;
        logic        fc;
        logic [2:0]  fcs;
        logic        chk_fcs;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } dec_t;
    typedef struct {
        logic [31:0] instr;
        dec_t        e;
    } vec_t;

    int nvec = 0;
    int nerr = 0;
    logic        m_valid = 1'b0;
    dec_t        m_dec;
    logic [31:0] m_pc = 32'h0;
    int          m_cnt = 0;
    logic [4:0]  ops [9] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                             5'b00000, 5'b01000, 5'b00100, 5'b01100};

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // cls is {LUP,UB,CB,MEM,ALU_IMM,ALU_REG}; immediates built arithmetically from the field weights
    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t r;
        int s = w[31] ? -1 : 0;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        r.cls = 6'd0; r.iop = 1'b0; r.fc = 1'b0; r.fcs = 3'd0; r.chk_fcs = 1'b0;
        r.imm = 32'd0; r.ill = 1'b0;
        r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
        case (w[6:2])
            5'b01101: begin r.cls = 6'b100000; r.iop = 1'b1; r.imm = w & 32'hFFFF_F000; end
            5'b00101: begin r.cls = 6'b100000; r.imm = w & 32'hFFFF_F000; end
            5'b11011: begin
                r.cls = 6'b010000; r.fcs = 3'd2; r.chk_fcs = 1'b1;
                r.imm = 32'(s * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2);
            end
            5'b11001: begin
                r.cls = 6'b010000; r.fcs = 3'd3; r.chk_fcs = 1'b1;
                r.imm = 32'(s * 2048 + int'(w[30:20]));
            end
            5'b11000: begin
                r.cls = 6'b001000; r.fcs = f3; r.chk_fcs = 1'b1;
                r.ill = (f3 == 3'd2) || (f3 == 3'd3);
                r.imm = 32'(s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2);
            end
            5'b00000: begin r.cls = 6'b000100; r.imm = 32'(s * 2048 + int'(w[30:20])); end
            5'b01000: begin
                r.cls = 6'b000100; r.fc = 1'b1; r.fcs = f3; r.chk_fcs = 1'b1;
                r.imm = 32'(s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]));
            end
            5'b00100: begin
                r.cls = 6'b000010; r.fcs = f3; r.chk_fcs = 1'b1;
                r.iop = (f3 == 3'd5) && w[30];
                r.imm = 32'(s * 2048 + int'(w[30:20]));
            end
            5'b01100: begin
                r.cls = 6'b000001; r.fcs = f3; r.chk_fcs = 1'b1;
                r.iop = f7 == 7'h20;
                r.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            default: r.ill = 1'b1;
        endcase
        if (w[1:0] != 2'b11) r.ill = 1'b1;
        if (r.ill) r.cls = 6'd0;
        return r;
    endfunction

    function automatic dec_t dut_dec();
        dec_t r;
        r.cls = {bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG};
        r.iop = bus.IOP; r.fc = bus.FC; r.fcs = bus.finite_control_sig; r.chk_fcs = 1'b0;
        r.imm = bus.imm; r.rs1 = bus.rs1; r.rs2 = bus.rs2; r.rd = bus.rd; r.ill = bus.illegal;
        return r;
    endfunction

    task automatic check_dec(input string tag, input dec_t e);
        dec_t a = dut_dec();
        cmp({tag, ".class"}, 32'(a.cls), 32'(e.cls));
        cmp({tag, ".illegal"}, 32'(a.ill), 32'(e.ill));
        cmp({tag, ".regs"}, 32'({a.rs1, a.rs2, a.rd}), 32'({e.rs1, e.rs2, e.rd}));
        if (!e.ill) begin
            cmp({tag, ".iop"}, 32'(a.iop), 32'(e.iop));
            cmp({tag, ".fc"}, 32'(a.fc), 32'(e.fc));
            cmp({tag, ".imm"}, a.imm, e.imm);
            if (e.chk_fcs) cmp({tag, ".fcs"}, 32'(a.fcs), 32'(e.fcs));
        end
    endtask

    task automatic check_reset(input string tag);
        cmp({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        cmp({tag, ".flags"}, 32'({bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG,
                                  bus.IOP, bus.FC, bus.illegal, bus.finite_control_sig}), 32'd0);
        cmp({tag, ".regs"}, 32'({bus.rs1, bus.rs2, bus.rd}), 32'd0);
        cmp({tag, ".imm"}, bus.imm, 32'd0);
        cmp({tag, ".pc_out"}, bus.pc_out, 32'd0);
        cmp({tag, ".illegal_count"}, 32'(bus.illegal_count), 32'd0);
    endtask

    // drives one cycle of inputs, advances the model on the edge and checks everything visible
    task automatic cycle(input logic iv, input logic [31:0] w, input logic [31:0] pc,
                         input logic ro, input logic fl, input logic r);
        logic acc;
        dec_t nd;
        bus.in_valid = iv; bus.instr = w; bus.pc_in = pc; bus.out_ready = ro; bus.flush = fl; rst = r;
        #1;
        if (!r) cmp("in_ready", 32'(bus.in_ready), 32'(!m_valid || ro));
        acc = iv && (!m_valid || ro) && !fl && !r;
        nd = ref_decode(w);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0; m_cnt = 0; m_pc = 32'h0;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1; m_dec = nd; m_pc = pc;
            if (nd.ill && m_cnt < 65535) m_cnt++;
        end else if (ro) begin
            m_valid = 1'b0;
        end
        cmp("out_valid", 32'(bus.out_valid), 32'(m_valid));
        cmp("illegal_count", 32'(bus.illegal_count), 32'(m_cnt));
        if (m_valid) begin
            check_dec("bundle", m_dec);
            cmp("pc_out", bus.pc_out, m_pc);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [5:0] cls, input logic iop,
                                input logic fc, input logic [2:0] fcs, input logic chk,
                                input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic ill);
        vec_t v;
        v.instr = instr;
        v.e.cls = cls; v.e.iop = iop; v.e.fc = fc; v.e.fcs = fcs; v.e.chk_fcs = chk;
        v.e.imm = imm; v.e.rs1 = rs1; v.e.rs2 = rs2; v.e.rd = rd; v.e.ill = ill;
        return v;
    endfunction

    initial begin
        vec_t tbl [16];
        int saved;
        m_dec = ref_decode(32'h0);
        tbl[0]  = mk(32'h002081B3, 6'b000001, 1'b0, 1'b0, 3'b000, 1'b1, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b0);
        tbl[1]  = mk(32'h4030D093, 6'b000010, 1'b1, 1'b0, 3'b101, 1'b1, 32'h00000403, 5'd1,  5'd3,  5'd1,  1'b0);
        tbl[2]  = mk(32'hFE000EE3, 6'b001000, 1'b0, 1'b0, 3'b000, 1'b1, 32'hFFFFFFFC, 5'd0,  5'd0,  5'd29, 1'b0);
        tbl[3]  = mk(32'h123450B7, 6'b100000, 1'b1, 1'b0, 3'b000, 1'b0, 32'h12345000, 5'd8,  5'd3,  5'd1,  1'b0);
        tbl[4]  = mk(32'h00001297, 6'b100000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00001000, 5'd0,  5'd0,  5'd5,  1'b0);
        tbl[5]  = mk(32'hFF9FF0EF, 6'b010000, 1'b0, 1'b0, 3'b010, 1'b1, 32'hFFFFFFF8, 5'd31, 5'd25, 5'd1,  1'b0);
        tbl[6]  = mk(32'h00008067, 6'b010000, 1'b0, 1'b0, 3'b011, 1'b1, 32'h00000000, 5'd1,  5'd0,  5'd0,  1'b0);
        tbl[7]  = mk(32'hFFC12283, 6'b000100, 1'b0, 1'b0, 3'b000, 1'b0, 32'hFFFFFFFC, 5'd2,  5'd28, 5'd5,  1'b0);
        tbl[8]  = mk(32'hFE71AA23, 6'b000100, 1'b0, 1'b1, 3'b010, 1'b1, 32'hFFFFFFF4, 5'd3,  5'd7,  5'd20, 1'b0);
        tbl[9]  = mk(32'h402081B3, 6'b000001, 1'b1, 1'b0, 3'b000, 1'b1, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b0);
        tbl[10] = mk(32'hFFF00093, 6'b000010, 1'b0, 1'b0, 3'b000, 1'b1, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1,  1'b0);
        tbl[11] = mk(32'h402091B3, 6'b000000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1);
        tbl[12] = mk(32'h00002063, 6'b000000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b1);
        tbl[13] = mk(32'hFFFFFFFF, 6'b000000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000000, 5'd31, 5'd31, 5'd31, 1'b1);
        tbl[14] = mk(32'h002081B0, 6'b000000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000000, 5'd1,  5'd2,  5'd3,  1'b1);
        tbl[15] = mk(32'h0000000F, 6'b000000, 1'b0, 1'b0, 3'b000, 1'b0, 32'h00000000, 5'd0,  5'd0,  5'd0,  1'b1);

        cycle(1'b1, 32'h002081B3, 32'h0, 1'b1, 1'b0, 1'b1);
        check_reset("reset");
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, tbl[i].instr, 32'(32'h1000 + 4 * i), 1'b1, 1'b0, 1'b0);
            check_dec($sformatf("vec%0d", i), tbl[i].e);
            cmp($sformatf("vec%0d.pc_out", i), bus.pc_out, 32'(32'h1000 + 4 * i));
        end
        cmp("table.illegal_count", 32'(bus.illegal_count), 32'd5);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        cycle(1'b1, 32'h123450B7, 32'h2000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h002081B3, 32'h2004, 1'b0, 1'b0, 1'b0);
            cmp("stall.in_ready", 32'(bus.in_ready), 32'd0);
            cmp("stall.imm", bus.imm, 32'h12345000);
            cmp("stall.lup", 32'(bus.LUP), 32'd1);
            cmp("stall.pc_out", bus.pc_out, 32'h2000);
        end
        cycle(1'b1, 32'h002081B3, 32'h2004, 1'b1, 1'b0, 1'b0);
        cmp("nobubble.out_valid", 32'(bus.out_valid), 32'd1);
        cmp("nobubble.alu_reg", 32'(bus.ALU_REG), 32'd1);
        cmp("nobubble.pc_out", bus.pc_out, 32'h2004);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        cycle(1'b1, 32'h002081B3, 32'h3000, 1'b1, 1'b0, 1'b0);
        saved = m_cnt;
        cycle(1'b1, 32'hFFFFFFFF, 32'h3004, 1'b1, 1'b1, 1'b0);
        cmp("flush.out_valid", 32'(bus.out_valid), 32'd0);
        cmp("flush.illegal_count", 32'(bus.illegal_count), 32'(saved));
        cycle(1'b1, 32'h002081B3, 32'h3008, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        cmp("flush_stall.out_valid", 32'(bus.out_valid), 32'd0);

        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b1, 32'hFFFFFFFF, 32'h4000, 1'b1, 1'b0, 1'b0);
        cmp("ill3.illegal_count", 32'(bus.illegal_count), 32'd3);
        cmp("ill3.illegal", 32'(bus.illegal), 32'd1);
        cmp("ill3.strobes", 32'({bus.LUP, bus.UB, bus.CB, bus.MEM, bus.ALU_IMM, bus.ALU_REG}), 32'd0);
        force dut.cnt = 16'hFFFF;
        #1;
        release dut.cnt;
        m_cnt = 65535;
        cycle(1'b1, 32'hFFFFFFFF, 32'h4004, 1'b1, 1'b0, 1'b0);
        cmp("sat.illegal_count", 32'(bus.illegal_count), 32'h0000FFFF);

        cycle(1'b1, 32'hFFFFFFFF, 32'h5000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h002081B3, 32'h5004, 1'b0, 1'b0, 1'b1);
        check_reset("rst_stall");
        rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        cmp("rst_stall.in_ready", 32'(bus.in_ready), 32'd1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 4) != 0) w[6:0] = {ops[$urandom_range(0, 8)], 2'b11};
            if (w[6:2] == 5'b01100 && $urandom_range(0, 1) == 1)
                w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            cycle($urandom_range(0, 3) != 0, w, $urandom, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 19) == 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
